// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-granular data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_t;

  // Index width for a power-of-two line count; never below one bit.
  function automatic int idx_width(input int depth_lines);
    return (depth_lines <= 2) ? 1 : $clog2(depth_lines);
  endfunction

endpackage

// File: rtl/dmem_line_responder_if.sv
// Request/acknowledge bundle between the data cache and the line memory.
// Latency: n/a (wires only).
// Backpressure: initiator holds enable_i until it sees the ack_o pulse.
// Signals: enable_i/write_i/addr_i/data_i from initiator, ack_o/data_o/err_o
// from the memory. Names keep the memory-side port view.
interface dmem_line_responder_if;
  import dmem_pkg::*;

  logic              enable_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              err_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, err_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, err_o
  );

endinterface

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, combinational read.
// Latency: write commits at the clock edge; read data follows idx the same cycle.
// Backpressure: none; accepts a write every cycle.
// Ports: clk_i, idx (line index), we (write enable), wr_dat, rd_dat.
// Contents are deliberately not reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = 9
) (
  input  logic              clk_i,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic [LINE_W-1:0] wr_dat,
  output logic [LINE_W-1:0] rd_dat
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wr_dat;
  end

  assign rd_dat = mem[idx];

endmodule

// File: rtl/dmem_line_responder.sv
// Line memory answering one read/write request at a time after LATENCY cycles.
// Latency: ack_o rises LATENCY edges after acceptance (the cycle right after it when LATENCY=1).
// Backpressure: requests are taken only in IDLE; the initiator holds enable_i until ack_o.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport of dmem_line_responder_if).
// Optional: define DMEM_RANGE_CHECK_EN to flag (sticky err_o) addresses above the array.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dmem_line_responder_if.slave  bus
);

  localparam int         IDX_W  = idx_width(DEPTH_LINES);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam bit         DIRECT = (LATENCY == 1);

  dmem_state_t       state;
  logic [7:0]        cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [LINE_W-1:0] data_q;
  logic              ack_q;
  logic [LINE_W-1:0] dout_q;

  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              finish_wait;
  logic [IDX_W-1:0]  arr_idx;
  logic              arr_we;
  logic [LINE_W-1:0] arr_wdat;
  logic [LINE_W-1:0] arr_rdat;

  assign req_idx     = bus.addr_i[OFFSET_W +: IDX_W];
  assign accept      = (state == IDLE) && bus.enable_i;
  assign finish_wait = (state == WAIT) && (cnt == 8'd0);

  // In IDLE the array looks at the live request so that a LATENCY=1 access
  // can complete on the acceptance edge; otherwise it sees the latched one.
  always_comb begin
    arr_idx  = idx_q;
    arr_wdat = data_q;
    arr_we   = 1'b0;
    if (state == IDLE) begin
      arr_idx  = req_idx;
      arr_wdat = bus.data_i;
    end
    if (!rst_i) begin
      if (DIRECT && accept && bus.write_i) arr_we = 1'b1;
      if (finish_wait && write_q)          arr_we = 1'b1;
    end
  end

  dmem_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .idx    (arr_idx),
    .we     (arr_we),
    .wr_dat (arr_wdat),
    .rd_dat (arr_rdat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable_i) begin
            idx_q   <= req_idx;
            write_q <= bus.write_i;
            data_q  <= bus.data_i;
            cnt     <= LAT_M1;
            if (DIRECT) begin
              state <= ACK;
              ack_q <= 1'b1;
              if (!bus.write_i) dout_q <= arr_rdat;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state <= ACK;
            ack_q <= 1'b1;
            // Writes leave data_o alone: the initiator may still be
            // consuming the previous read line.
            if (!write_q) dout_q <= arr_rdat;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          // A still-high enable_i here is the tail of the request just served.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = dout_q;

  logic unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;

  // Any address bit above the index field means the access aliases.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (accept && ((bus.addr_i >> (OFFSET_W + IDX_W)) != 32'd0)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o   = err_q;
  assign unused_addr = ^bus.addr_i[OFFSET_W-1:0];
`else
  assign bus.err_o   = 1'b0;
  assign unused_addr = ^{bus.addr_i[31:OFFSET_W+IDX_W], bus.addr_i[OFFSET_W-1:0]};
`endif

endmodule
